// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared encodings, defaults and helpers for the frame scheduler.
package frame_sched_pkg;
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        ARM         = 4'd1,
        TRIGGER     = 4'd2,
        WAIT_FRAME  = 4'd3,
        WAIT_PERIOD = 4'd4,
        ERROR       = 4'd5
    } state_t;
    localparam logic [1:0] MODE_SINGLE     = 2'd0;
    localparam logic [1:0] MODE_BURST      = 2'd1;
    localparam logic [1:0] MODE_CONTINUOUS = 2'd2;
    localparam logic [1:0] MODE_SINGLE_ALT = 2'd3;
    localparam int DEF_TIMEOUT_CYCLES = 2000000;
    localparam int DEF_MIN_PERIOD     = 1100;
    function automatic logic [31:0] clamp_period(input logic [31:0] p, input logic [31:0] min_p);
        return (p < min_p) ? min_p : p;
    endfunction
endpackage

// File: rtl/period_timer.sv
// period_timer: down-counter that flags expiry so triggers are spaced exactly one period apart.
module period_timer (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] period,
    output logic        expire,
    output logic        done
);
    logic [31:0] count;
    // Loaded at the end of TRIGGER; the two-cycle ARM->TRIGGER path absorbs the remaining spacing.
    always_ff @(posedge master_clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= period - 32'd2;
        else if (count != '0)
            count <= count - 32'd1;
    end
    assign expire = (count == 32'd1);
    assign done   = (count == '0);
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences sensor frame triggers in single/burst/continuous modes.
// Define FRAME_SCHED_WATCHDOG_EN to enable the WAIT_FRAME watchdog and the ERROR state.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MIN_PERIOD     = DEF_MIN_PERIOD
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [1:0]  cfg_mode,
    input  logic [31:0] cfg_period,
    input  logic [15:0] cfg_burst_len,
    input  logic        frame_done,
    input  logic        sink_ready,
    output logic        frame_trigger,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] overrun_count,
    output logic        timeout_err,
    output logic [3:0]  dbg_sched_state
);
    state_t      state, next_state;
    logic [31:0] period_q;
    logic [15:0] burst_q;
    logic [1:0]  mode_q;
    logic        stop_pending;
    logic        timer_expire, timer_done, timeout;
    logic        start_ok, in_wf, stopping, last_frame;
    logic [15:0] count_inc;

    assign start_ok   = (state == IDLE) && cmd_start && !cmd_stop;
    assign in_wf      = (state == WAIT_FRAME);
    assign stopping   = stop_pending || cmd_stop;
    assign count_inc  = frame_count + 16'd1;
    assign last_frame = (mode_q == MODE_BURST) ? (count_inc == burst_q) : (mode_q != MODE_CONTINUOUS);

    period_timer u_timer (
        .master_clock(master_clock),
        .reset(reset),
        .load(state == TRIGGER),
        .period(period_q),
        .expire(timer_expire),
        .done(timer_done)
    );

`ifdef FRAME_SCHED_WATCHDOG_EN
    logic [31:0] wd_count;
    always_ff @(posedge master_clock) begin
        if (reset) begin
            wd_count    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_count    <= in_wf ? wd_count + 32'd1 : '0;
            timeout_err <= (state == ERROR);
        end
    end
    assign timeout = in_wf && !frame_done && (wd_count == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge master_clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        next_state = start_ok ? ARM : IDLE;
            ARM:         next_state = cmd_stop ? IDLE : (sink_ready ? TRIGGER : ARM);
            TRIGGER:     next_state = cmd_stop ? IDLE : WAIT_FRAME;
            WAIT_FRAME:  next_state = frame_done ? ((stopping || last_frame) ? IDLE :
                                                   (timer_expire || timer_done) ? ARM : WAIT_PERIOD) :
                                      timeout ? (stopping ? IDLE : ERROR) : WAIT_FRAME;
            WAIT_PERIOD: next_state = cmd_stop ? IDLE : (timer_expire ? ARM : WAIT_PERIOD);
            ERROR:       next_state = cmd_stop ? IDLE : ERROR;
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            frame_trigger   <= 1'b0;
            busy            <= 1'b0;
            dbg_sched_state <= 4'd0;
        end else begin
            frame_trigger   <= (state == TRIGGER);
            busy            <= (state != IDLE);
            dbg_sched_state <= state;
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            period_q      <= '0;
            burst_q       <= '0;
            mode_q        <= MODE_SINGLE;
            stop_pending  <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            stop_pending <= in_wf && stopping && (next_state == WAIT_FRAME);
            if (start_ok) begin
                period_q      <= clamp_period(cfg_period, 32'(MIN_PERIOD));
                burst_q       <= (cfg_burst_len == '0) ? 16'd1 : cfg_burst_len;
                mode_q        <= cfg_mode;
                frame_count   <= '0;
                overrun_count <= '0;
            end else begin
                if (in_wf && frame_done)
                    frame_count <= count_inc;
                if (in_wf && timer_expire && overrun_count != 16'hFFFF)
                    overrun_count <= overrun_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed self-checking bench for frame_scheduler.
// Exercises the watchdog path when FRAME_SCHED_WATCHDOG_EN is defined.
module tb_frame_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] cfg_period = 32'd2000;
    logic [15:0] cfg_burst_len = 16'd1;
    logic        frame_done = 1'b0;
    logic        sink_ready = 1'b1;
    logic        frame_trigger, busy, timeout_err;
    logic [15:0] frame_count, overrun_count;
    logic [3:0]  dbg_sched_state;
    int vectors = 0;
    int errs = 0;
    int trig_cnt = 0;
    int base;
    int n;

    frame_scheduler #(.TIMEOUT_CYCLES(100), .MIN_PERIOD(1100)) dut (
        .master_clock(clk),
        .reset(reset),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .cfg_mode(cfg_mode),
        .cfg_period(cfg_period),
        .cfg_burst_len(cfg_burst_len),
        .frame_done(frame_done),
        .sink_ready(sink_ready),
        .frame_trigger(frame_trigger),
        .busy(busy),
        .frame_count(frame_count),
        .overrun_count(overrun_count),
        .timeout_err(timeout_err),
        .dbg_sched_state(dbg_sched_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_trigger) trig_cnt <= trig_cnt + 1;

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
    endtask

    task automatic wait_trig(input int maxn, output int cnt);
        cnt = 0;
        while (frame_trigger !== 1'b1 && cnt < maxn) begin
            tick(1);
            cnt++;
        end
        chk("trigger_seen", frame_trigger, 1);
    endtask

    initial begin
        tick(2);
        chk("rst_trig", frame_trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_oc", overrun_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_dbg", dbg_sched_state, 0);
        reset = 1'b0;
        tick(1);

        // single mode, period 2000
        base = trig_cnt;
        pulse_start();
        chk("single_lat1", frame_trigger, 0);
        tick(1);
        chk("single_lat2", frame_trigger, 0);
        chk("single_busy", busy, 1);
        tick(1);
        chk("single_trig", frame_trigger, 1);
        chk("single_dbg_trig", dbg_sched_state, 2);
        tick(1);
        chk("single_trig_off", frame_trigger, 0);
        chk("single_dbg_wf", dbg_sched_state, 3);
        tick(1400);
        chk("single_one_trig", trig_cnt - base, 1);
        pulse_done();
        chk("single_fc", frame_count, 1);
        tick(1);
        chk("single_idle_busy", busy, 0);
        chk("single_idle_dbg", dbg_sched_state, 0);

        // burst of 3, cfg changes and cmd_start while busy are ignored
        cfg_mode = 2'd1;
        cfg_burst_len = 16'd3;
        cfg_period = 32'd2000;
        base = trig_cnt;
        pulse_start();
        cfg_period = 32'd5000;
        cfg_mode = 2'd2;
        wait_trig(10, n);
        chk("burst_lat", n, 2);
        for (int f = 1; f <= 3; f++) begin
            if (f > 1) begin
                wait_trig(3000, n);
                chk("burst_spacing", 1200 + n, 2000);
            end
            tick(5);
            pulse_start();
            tick(1193);
            pulse_done();
        end
        chk("burst_fc", frame_count, 3);
        tick(1);
        chk("burst_idle", busy, 0);
        chk("burst_oc", overrun_count, 0);
        chk("burst_trigs", trig_cnt - base, 3);

        // continuous, period 1200, frames take 1500 -> one overrun per frame
        cfg_mode = 2'd2;
        cfg_period = 32'd1200;
        base = trig_cnt;
        pulse_start();
        wait_trig(10, n);
        for (int f = 1; f <= 3; f++) begin
            tick(1499);
            pulse_done();
            chk("cont_oc", overrun_count, f);
            tick(1);
            chk("cont_trig_d1", frame_trigger, 0);
            tick(1);
            chk("cont_trig_d2", frame_trigger, 1);
        end
        tick(10);
        pulse_stop();
        tick(100);
        pulse_done();
        chk("stop_fc", frame_count, 4);
        tick(1);
        chk("stop_idle", busy, 0);
        tick(2000);
        chk("stop_no_trig", trig_cnt - base, 4);
        chk("stop_oc", overrun_count, 3);

        // sink_ready low holds ARM; period 10 clamps to 1100
        cfg_mode = 2'd1;
        cfg_burst_len = 16'd2;
        cfg_period = 32'd10;
        sink_ready = 1'b0;
        base = trig_cnt;
        pulse_start();
        tick(500);
        chk("sink_no_trig", trig_cnt - base, 0);
        chk("sink_dbg_arm", dbg_sched_state, 1);
        sink_ready = 1'b1;
        tick(1);
        chk("sink_lat1", frame_trigger, 0);
        tick(1);
        chk("sink_lat2", frame_trigger, 1);
        tick(100);
        pulse_done();
        wait_trig(2000, n);
        chk("clamp_spacing", 101 + n, 1100);
        tick(100);
        pulse_done();
        chk("clamp_fc", frame_count, 2);
        tick(1);
        chk("clamp_idle", busy, 0);

        // mode 3 and burst_len 0 both behave as a single frame
        for (int k = 0; k < 2; k++) begin
            cfg_mode = (k == 0) ? 2'd3 : 2'd1;
            cfg_burst_len = 16'd0;
            pulse_start();
            wait_trig(10, n);
            tick(50);
            pulse_done();
            tick(1);
            chk("one_frame_idle", busy, 0);
            chk("one_frame_fc", frame_count, 1);
        end

        // start+stop together, stray frame_done in IDLE
        cmd_start = 1'b1;
        cmd_stop = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        tick(1);
        chk("startstop_busy", busy, 0);
        chk("startstop_dbg", dbg_sched_state, 0);
        pulse_done();
        tick(1);
        chk("idle_done_fc", frame_count, 1);

        // reset while TRIGGER is pending suppresses the pulse
        cfg_mode = 2'd0;
        base = trig_cnt;
        pulse_start();
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("midrst_trig", frame_trigger, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fc", frame_count, 0);
        reset = 1'b0;
        tick(5);
        chk("midrst_no_trig", trig_cnt - base, 0);

`ifdef FRAME_SCHED_WATCHDOG_EN
        pulse_start();
        wait_trig(10, n);
        tick(100);
        chk("wd_still_wf", dbg_sched_state, 3);
        tick(1);
        chk("wd_error", dbg_sched_state, 5);
        chk("wd_terr", timeout_err, 1);
        chk("wd_busy", busy, 1);
        pulse_stop();
        tick(1);
        chk("wd_clear", timeout_err, 0);
        chk("wd_idle", busy, 0);
`else
        pulse_start();
        wait_trig(10, n);
        tick(150);
        chk("nowd_terr", timeout_err, 0);
        chk("nowd_wf", dbg_sched_state, 3);
        pulse_stop();
        tick(5);
        pulse_done();
        tick(1);
        chk("nowd_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, is the watchdog limit in master_clock cycles (50 ms at 40 MHz).
REQ-002 Parameter MIN_PERIOD, default 1100, is the smallest allowed trigger-to-trigger spacing in cycles.
REQ-003 Port master_clock  in  1  is the single clock (40 MHz); all logic is on its rising edge.
REQ-004 Port reset  in  1  is a synchronous, active-high reset.
REQ-005 Port cmd_start  in  1  is a one-cycle pulse that starts a sequence.
REQ-006 Port cmd_stop  in  1  is a one-cycle pulse that requests a stop.
REQ-007 Port cfg_mode  in  2  selects the mode: 0 single, 1 burst, 2 continuous, 3 treated as single.
REQ-008 Port cfg_period  in  32  is the trigger-to-trigger spacing in cycles.
REQ-009 Port cfg_burst_len  in  16  is the number of frames in burst mode.
REQ-010 Port frame_done  in  1  is a one-cycle pulse from the acquisition path when the last pixel (index 1023) of a frame is accepted.
REQ-011 Port sink_ready  in  1  is high when the packet path can accept a new frame.
REQ-012 Port frame_trigger  out  1  is a one-cycle frame-start pulse to the sensor driver.
REQ-013 Port busy  out  1  is high in every state except IDLE.
REQ-014 Port frame_count  out  16  counts completed frames in the current sequence.
REQ-015 Port overrun_count  out  16  counts period expiries that occur while a frame is still in flight.
REQ-016 Port timeout_err  out  1  is a sticky watchdog error flag.
REQ-017 Port dbg_sched_state  out  4  is a registered copy of the state encoding.

Function
REQ-018 The state machine SHALL use these states and encodings: IDLE=0, ARM=1, TRIGGER=2, WAIT_FRAME=3, WAIT_PERIOD=4, ERROR=5; all outputs SHALL be registered.
REQ-019 In IDLE, cmd_start SHALL latch the configuration into shadow registers and move the state to ARM.
- cfg_period below MIN_PERIOD is clamped to MIN_PERIOD.
- cfg_burst_len=0 is treated as 1.
- frame_count and overrun_count are cleared.
REQ-020 ARM SHALL wait for sink_ready=1, then go to TRIGGER; frame_trigger SHALL be high for exactly the one cycle the state is TRIGGER, which is the cycle after leaving ARM.
REQ-021 With sink_ready already high, frame_trigger SHALL rise exactly 2 cycles after cmd_start is sampled.
REQ-022 The period timer SHALL reload to the shadow period in the TRIGGER cycle; TRIGGER SHALL then go to WAIT_FRAME.
REQ-023 frame_done in WAIT_FRAME SHALL increment frame_count (wrapping at 16 bits).
- If single mode, or burst mode with frame_count reaching burst_len, the state goes to IDLE.
- Otherwise, the state goes to WAIT_PERIOD.
REQ-024 WAIT_PERIOD SHALL go to ARM when the timer expires, so that trigger-to-trigger spacing is exactly the shadow period when sink_ready is high and frame_done arrives earlier.
REQ-025 If the timer expires during WAIT_FRAME, overrun_count SHALL increment (saturating at 0xFFFF).
- After frame_done, the state SHALL go directly to ARM, skipping WAIT_PERIOD.
- Only one trigger is ever outstanding.
REQ-026 cmd_stop SHALL behave as follows:
- In ARM or WAIT_PERIOD: next state is IDLE.
- In TRIGGER: the pulse completes, then the state goes to IDLE.
- In WAIT_FRAME: a stop-pending flag is set; the state goes to IDLE on frame_done or on timeout.
REQ-027 cmd_start while busy SHALL be ignored; cmd_start and cmd_stop together in IDLE SHALL leave the block in IDLE.
REQ-028 frame_done outside WAIT_FRAME SHALL be ignored and SHALL NOT count.
REQ-029 Changes to cfg_* inputs while busy SHALL have no effect until the next cmd_start.

Reset
REQ-030 On reset, the state SHALL be IDLE, all counters and the timer SHALL be 0, and frame_trigger, busy, timeout_err, the stop-pending flag and dbg_sched_state SHALL be 0.
REQ-031 Reset in any state, including mid-frame, SHALL take effect on the next edge with no further trigger pulse.

Configuration
REQ-032 With macro FRAME_SCHED_WATCHDOG_EN defined, a watchdog counter SHALL run in WAIT_FRAME.
- When it reaches TIMEOUT_CYCLES without frame_done, the state goes to ERROR and timeout_err is set.
- ERROR holds (busy=1) until cmd_stop, which clears timeout_err and returns the state to IDLE.
REQ-033 Without FRAME_SCHED_WATCHDOG_EN, there SHALL be no watchdog counter, timeout_err SHALL be tied to 0, and ERROR SHALL be unreachable.

Structure
REQ-034 The state encodings, mode encodings and the MIN_PERIOD/TIMEOUT_CYCLES defaults SHALL live in the shared package frame_sched_pkg.
REQ-035 The period timer (load, decrement, expiry flag) SHALL be the sub-module period_timer; the state machine and counters SHALL remain in frame_scheduler.

Verification
REQ-036 Single mode, period 2000, sink_ready=1, cmd_start at cycle 10 -> frame_trigger high at cycle 12 only; frame_done at 1500 -> IDLE at 1501, frame_count=1.
REQ-037 Burst mode, len 3, period 2000, frame_done 1200 cycles after each trigger -> triggers at 12, 2012, 4012; frame_count=3; IDLE; overrun_count=0.
REQ-038 Continuous mode, period 1200, frame_done 1500 cycles after each trigger -> overrun_count increments once per frame; each trigger comes 2 cycles after the prior frame_done.
REQ-039 sink_ready=0 for 500 cycles after cmd_start -> no trigger; frame_trigger 2 cycles after sink_ready rises; cfg_period=10 is clamped to 1100 spacing.
REQ-040 cmd_stop during WAIT_FRAME -> no further trigger; IDLE one cycle after frame_done; cmd_start plus cmd_stop together in IDLE -> stays IDLE.
REQ-041 With FRAME_SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=100, no frame_done -> ERROR and timeout_err=1 after 100 WAIT_FRAME cycles; cmd_stop -> IDLE with timeout_err=0.
